// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: lane select codes, default frame
// length and the flush FSM state type.
package fft_pkg;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    localparam int FRAME_LEN_DEFAULT = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } demux_state_t;

    // Round-robin successor of a lane pointer.
    function automatic logic [1:0] next_lane(input logic [1:0] lane);
        return lane + 2'd1;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-deep valid/ready holding register for a single demux output lane.
// A write in the same cycle as a read refills the slot without a bubble.
module demux_lane_reg #(
    parameter int W = 44
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         valid,
    output logic [W-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            // NOTE: the data register is reset too because it drives a visible port with a defined reset value.
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            data  <= wr_data;
        end else if (rd_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1_4_stream.sv
// 1:4 stream demux for packed complex samples with per-lane holding registers,
// frame counting and drain-and-restart flush. DEMUX_STALL_CNT_EN adds stall_cnt.
module demux1_4_stream
    import fft_pkg::*;
#(
    parameter int number_bits = 22,
    parameter int FRAME_LEN   = FRAME_LEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*number_bits-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     auto_rr,
    input  logic [1:0]               in_sel,
    input  logic                     flush,
    output logic [2*number_bits-1:0] out_data0,
    output logic [2*number_bits-1:0] out_data1,
    output logic [2*number_bits-1:0] out_data2,
    output logic [2*number_bits-1:0] out_data3,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic                     frame_done,
    output logic                     busy_flush
`ifdef DEMUX_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int                DW       = 2 * number_bits;
    localparam int                CW       = $clog2(FRAME_LEN);
    localparam logic [CW-1:0]     CNT_LAST = CW'(FRAME_LEN - 1);

    demux_state_t  state;
    logic [1:0]    rr_ptr;
    logic [CW-1:0] count;
    logic [1:0]    tgt;
    logic          accept;
    logic [3:0]    wr_en;
    logic [3:0]    lane_valid;
    logic [DW-1:0] lane_data [4];

    assign tgt = auto_rr ? rr_ptr : in_sel;

    // Ready looks only at the target lane and the FSM, never at in_valid.
    always_comb begin
        in_ready = (state == RUN) && (!lane_valid[tgt] || out_ready[tgt]);
    end

    assign accept = in_valid && in_ready;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_en = 4'b0000;
        if (accept) begin
            unique case (tgt)
                LANE0: wr_en[0] = 1'b1;
                LANE1: wr_en[1] = 1'b1;
                LANE2: wr_en[2] = 1'b1;
                LANE3: wr_en[3] = 1'b1;
            endcase
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        demux_lane_reg #(
            .W(DW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[k]),
            .wr_data  (in_data),
            .rd_ready (out_ready[k]),
            .valid    (lane_valid[k]),
            .data     (lane_data[k])
        );
    end

    assign out_valid = lane_valid;
    assign out_data0 = lane_data[0];
    assign out_data1 = lane_data[1];
    assign out_data2 = lane_data[2];
    assign out_data3 = lane_data[3];

    // Pointer, frame counter and flush FSM share one register block.
    // In FLUSH in_ready is low, so no accept can collide with the restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            busy_flush <= 1'b0;
            rr_ptr     <= LANE0;
            count      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && (count == CNT_LAST);

            if (accept) begin
                count <= (count == CNT_LAST) ? '0 : count + 1'b1;
                if (auto_rr) begin
                    rr_ptr <= next_lane(rr_ptr);
                end
            end

            unique case (state)
                RUN: begin
                    if (flush) begin
                        state      <= FLUSH;
                        busy_flush <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (lane_valid == 4'b0000) begin
                        state      <= RUN;
                        busy_flush <= 1'b0;
                        rr_ptr     <= LANE0;
                        count      <= '0;
                    end
                end
            endcase
        end
    end

`ifdef DEMUX_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
